// File: rtl/loader_pkg.sv
// Shared types for the instruction-memory loader: FSM states, length width and stream field order.
package loader_pkg;

   localparam int LEN_W = 16;

   typedef enum logic [2:0] {
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   // Order of fields on the wire; the checksum field exists only when LOADER_CHECKSUM_EN is defined.
   typedef enum logic [1:0] {
      F_LEN_LO,
      F_LEN_HI,
      F_PAYLOAD,
      F_CSUM
   } field_t;

   function automatic logic accepts_byte(input state_t s);
      return (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_DATA) || (s == S_CHECK);
   endfunction

endpackage

// File: rtl/load_csum.sv
// XOR accumulator over payload bytes; clr has priority over en.
module load_csum (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] din,
   output logic [7:0] value
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         value <= '0;
      end else if (en) begin
         value <= value ^ din;
      end
   end

endmodule

// File: rtl/inst_loader.sv
// Length-prefixed byte-stream loader for instruction memory; holds the CPU until a full image is written.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module inst_loader
   import loader_pkg::*;
#(
   parameter int MEM_BYTES = 256,
   parameter int ADDR_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [LEN_W-1:0]  byte_count
);

   localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(MEM_BYTES);

`ifdef LOADER_CHECKSUM_EN
   localparam state_t S_PAYLOAD_END = S_CHECK;
`else
   localparam state_t S_PAYLOAD_END = S_DONE;
`endif

   state_t           state, state_nxt;
   logic [7:0]       len_lo;
   logic [LEN_W-1:0] len;
   logic [LEN_W:0]   len_new;
   logic             xfer;
   logic             restart;

   assign in_ready = accepts_byte(state);
   assign xfer     = in_valid && in_ready;
   assign restart  = start && ((state == S_DONE) || (state == S_ERROR));
   // One extra bit so lengths above MEM_BYTES compare correctly at the 16-bit limit.
   assign len_new  = {1'b0, in_data, len_lo};

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] csum;

   load_csum u_csum (
      .clk   (clk),
      .rst   (rst),
      .clr   (restart),
      .en    (xfer && (state == S_DATA)),
      .din   (in_data),
      .value (csum)
   );
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_LEN_LO;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_LEN_LO: begin
            if (xfer) state_nxt = S_LEN_HI;
         end
         S_LEN_HI: begin
            if (xfer) begin
               if (len_new > MAX_LEN)    state_nxt = S_ERROR;
               else if (len_new == '0)   state_nxt = S_PAYLOAD_END;
               else                      state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (xfer && ((byte_count + 16'd1) == len)) state_nxt = S_PAYLOAD_END;
         end
`ifdef LOADER_CHECKSUM_EN
         S_CHECK: begin
            if (xfer) state_nxt = (in_data == csum) ? S_DONE : S_ERROR;
         end
`endif
         S_DONE, S_ERROR: begin
            if (start) state_nxt = S_LEN_LO;
         end
         default: state_nxt = S_ERROR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         len_lo     <= '0;
         len        <= '0;
         byte_count <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         done       <= 1'b0;
         error      <= 1'b0;
         cpu_hold   <= 1'b1;
      end else begin
         mem_we   <= 1'b0;
         done     <= (state_nxt == S_DONE);
         error    <= (state_nxt == S_ERROR);
         cpu_hold <= (state_nxt != S_DONE);
         if (xfer && (state == S_LEN_LO)) len_lo <= in_data;
         if (xfer && (state == S_LEN_HI)) len <= len_new[LEN_W-1:0];
         if (xfer && (state == S_DATA)) begin
            mem_we     <= 1'b1;
            mem_addr   <= byte_count[ADDR_W-1:0];
            mem_wdata  <= in_data;
            byte_count <= byte_count + 16'd1;
         end
         if (restart) byte_count <= '0;
      end
   end

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: fixed vectors, corner-case sequences and randomized images against a stream-level model.
module tb_inst_loader;

   localparam int MEMB = 256;
   localparam int AW   = 8;

   logic          clk = 1'b0;
   logic          rst, start, in_valid;
   logic [7:0]    in_data;
   logic          in_ready, mem_we, cpu_hold, done, error;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic [15:0]   byte_count;

   always #5 clk = ~clk;

   inst_loader #(.MEM_BYTES(MEMB), .ADDR_W(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .error      (error),
      .byte_count (byte_count)
   );

   typedef struct {
      int n;
      int gap;
      bit bad;
      bit exp_done;
      bit exp_err;
      int exp_cnt;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] stream[$];
   logic [7:0] part[$];
   logic [7:0] wa[$];
   logic [7:0] wd[$];
   logic [7:0] m_pay[$];
   bit         m_done, m_err;
   int         n_pass  = 0;
   int         n_total = 0;

   // Write log as seen by the memory port.
   always @(negedge clk) begin
      if (mem_we) begin
         wa.push_back(mem_addr);
         wd.push_back(mem_wdata);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic build(input int n, input bit bad);
      logic [7:0] x;
      logic [15:0] n16;
      n16 = 16'(n);
      x = 8'h00;
      stream.delete();
      stream.push_back(n16[7:0]);
      stream.push_back(n16[15:8]);
      if (n <= MEMB) begin
         for (int i = 0; i < n; i++) begin
            stream.push_back(8'($urandom_range(255)));
            x = x ^ stream[2 + i];
         end
`ifdef LOADER_CHECKSUM_EN
         stream.push_back(bad ? (x ^ 8'h01) : x);
`endif
      end
   endtask

   // Reference: parse the stream as the format describes it.
   task automatic ref_model();
      int n;
      logic [7:0] x;
      n = int'(stream[0]) | (int'(stream[1]) << 8);
      m_pay.delete();
      m_done = 1'b0;
      m_err  = 1'b0;
      if (n > MEMB) begin
         m_err = 1'b1;
      end else begin
         x = 8'h00;
         for (int i = 0; i < n; i++) begin
            m_pay.push_back(stream[2 + i]);
            x = x ^ stream[2 + i];
         end
         m_done = 1'b1;
`ifdef LOADER_CHECKSUM_EN
         if (stream[2 + n] != x) begin
            m_done = 1'b0;
            m_err  = 1'b1;
         end
`endif
      end
   endtask

   task automatic send(input logic [7:0] b[$], input int gap, output int cyc);
      int i;
      bit hs;
      i   = 0;
      cyc = 0;
      while (i < b.size() && cyc < 4000) begin
         @(negedge clk);
         if (gap > 0 && int'($urandom_range(99)) < gap) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
         end else begin
            in_valid = 1'b1;
            in_data  = b[i];
         end
         #1 hs = in_valid && in_ready;
         @(posedge clk);
         if (hs) i++;
         cyc++;
      end
      if (i < b.size()) check("send_timeout", 32'(i), 32'(b.size()));
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic run_image(input string tag, input int gap, input bit ed, input bit ee, input int ec);
      int cyc;
      wa.delete();
      wd.delete();
      ref_model();
      send(stream, gap, cyc);
      #1;
      check({tag, " done"},       32'(done),       32'(ed));
      check({tag, " error"},      32'(error),      32'(ee));
      check({tag, " cpu_hold"},   32'(cpu_hold),   32'(!ed));
      check({tag, " in_ready"},   32'(in_ready),   32'(0));
      check({tag, " byte_count"}, 32'(byte_count), 32'(ec));
      check({tag, " n_writes"},   32'(wa.size()),  32'(m_pay.size()));
      for (int i = 0; i < wa.size() && i < m_pay.size(); i++) begin
         check($sformatf("%s addr[%0d]", tag, i), 32'(wa[i]), 32'(i));
         check($sformatf("%s data[%0d]", tag, i), 32'(wd[i]), 32'(m_pay[i]));
      end
      if (gap == 0) check({tag, " cycles"}, 32'(cyc), 32'(stream.size()));
   endtask

   task automatic restart();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      check("restart in_ready",   32'(in_ready),   32'(1));
      check("restart byte_count", 32'(byte_count), 32'(0));
      check("restart done",       32'(done),       32'(0));
      check("restart error",      32'(error),      32'(0));
      check("restart cpu_hold",   32'(cpu_hold),   32'(1));
   endtask

   task automatic check_reset(input string tag);
      check({tag, " in_ready"},   32'(in_ready),   32'(1));
      check({tag, " mem_we"},     32'(mem_we),     32'(0));
      check({tag, " mem_addr"},   32'(mem_addr),   32'(0));
      check({tag, " mem_wdata"},  32'(mem_wdata),  32'(0));
      check({tag, " cpu_hold"},   32'(cpu_hold),   32'(1));
      check({tag, " done"},       32'(done),       32'(0));
      check({tag, " error"},      32'(error),      32'(0));
      check({tag, " byte_count"}, 32'(byte_count), 32'(0));
   endtask

   initial begin
      int cyc;
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1 check_reset("por");

      stream = {8'h04, 8'h00, 8'h20, 8'h08, 8'h00, 8'h64};
`ifdef LOADER_CHECKSUM_EN
      stream.push_back(8'h20 ^ 8'h08 ^ 8'h00 ^ 8'h64);
`endif
      run_image("img4", 0, 1'b1, 1'b0, 4);
      check("img4 data3", 32'(wd.size() > 3 ? wd[3] : 8'hxx), 32'h64);
      restart();

      vecs.push_back('{n: 1,        gap: 0,  bad: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_cnt: 1});
      vecs.push_back('{n: 256,      gap: 0,  bad: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_cnt: 256});
      vecs.push_back('{n: 257,      gap: 0,  bad: 1'b0, exp_done: 1'b0, exp_err: 1'b1, exp_cnt: 0});
      vecs.push_back('{n: 0,        gap: 0,  bad: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_cnt: 0});
      vecs.push_back('{n: 8,        gap: 50, bad: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_cnt: 8});
      vecs.push_back('{n: 8,        gap: 0,  bad: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_cnt: 8});
      vecs.push_back('{n: 16'hFFFF, gap: 0,  bad: 1'b0, exp_done: 1'b0, exp_err: 1'b1, exp_cnt: 0});
`ifdef LOADER_CHECKSUM_EN
      vecs.push_back('{n: 5,        gap: 30, bad: 1'b1, exp_done: 1'b0, exp_err: 1'b1, exp_cnt: 5});
`endif
      foreach (vecs[k]) begin
         build(vecs[k].n, vecs[k].bad);
         run_image($sformatf("vec%0d", k), vecs[k].gap, vecs[k].exp_done, vecs[k].exp_err, vecs[k].exp_cnt);
         restart();
      end

      // Reset after 3 of 8 payload bytes, then a fresh 2-byte image.
      build(8, 1'b0);
      part = stream[0:4];
      send(part, 0, cyc);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1 check_reset("midrst");
      build(2, 1'b0);
      run_image("after_rst", 0, 1'b1, 1'b0, 2);
      restart();

`ifdef LOADER_CHECKSUM_EN
      stream = {8'h02, 8'h00, 8'h12, 8'h34, 8'h26};
      run_image("csum_ok", 0, 1'b1, 1'b0, 2);
      restart();
      stream = {8'h02, 8'h00, 8'h12, 8'h34, 8'h27};
      run_image("csum_bad", 0, 1'b0, 1'b1, 2);
      restart();
      stream = {8'h02, 8'h00, 8'h12, 8'h34, 8'h26};
      run_image("csum_again", 20, 1'b1, 1'b0, 2);
      restart();
      stream = {8'h00, 8'h00, 8'h00};
      run_image("csum_n0", 0, 1'b1, 1'b0, 0);
      restart();
`endif

      for (int r = 0; r < 20; r++) begin
         bit bad;
         bad = 1'b0;
`ifdef LOADER_CHECKSUM_EN
         bad = 1'($urandom_range(1));
`endif
         build(int'($urandom_range(MEMB + 3)), bad);
         ref_model();
         run_image($sformatf("rnd%0d", r), int'($urandom_range(60)), m_done, m_err, m_pay.size());
         restart();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/inst_loader.md
# inst_loader

Program loader for the single-cycle CPU's byte-wide instruction memory. It accepts a length-prefixed byte stream over a valid/ready handshake and writes each payload byte into consecutive memory addresses. This fills instruction memory at power-up, replacing hard-coded initial contents. While loading, it holds the CPU stalled; it releases the CPU only after a complete, well-formed image has been written.

## Interface
Parameters:
- MEM_BYTES, 256, instruction memory size in bytes; maximum accepted image length.
- ADDR_W, 8, width of mem_addr; must satisfy 2^ADDR_W >= MEM_BYTES.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; restarts loading from DONE or ERROR; ignored in all other states.
- in_valid  input  1  host presents a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  write strobe toward the instruction memory write port.
- mem_addr  output  ADDR_W  byte address.
- mem_wdata  output  8  byte to write.
- cpu_hold  output  1  high keeps the CPU PC and register-file writes frozen.
- done  output  1  image loaded successfully.
- error  output  1  load aborted.
- byte_count  output  16  payload bytes written so far.

## Operation
- Stream format: LEN_LO, LEN_HI (16-bit little-endian payload length N), then N payload bytes. When the checksum is compiled in, one checksum byte follows the payload.
- A byte transfers when in_valid && in_ready. At most one byte transfers per cycle. in_ready depends only on the current state, never on in_valid.
- States: LEN_LO → LEN_HI → DATA → (CHECK) → DONE; any state may go → ERROR.
  - LEN_LO: accept low length byte.
  - LEN_HI: accept high byte; form N.
    - N > MEM_BYTES → ERROR.
    - N == 0 → DONE (or CHECK if the checksum is enabled).
    - Otherwise → DATA.
  - DATA: each accepted byte is written at address byte_count[ADDR_W-1:0], then byte_count increments. After the Nth byte → DONE (or CHECK).
  - CHECK: accept one byte; if it equals the running value → DONE, else → ERROR.
  - DONE / ERROR: in_ready=0. A start pulse clears byte_count and enters LEN_LO.
- in_ready=1 in LEN_LO, LEN_HI, DATA and CHECK; 0 otherwise.
- cpu_hold=1 in every state except DONE. In ERROR the CPU stays held.
- Addresses are written in ascending order, starting at 0, with no wrap. The N ≤ MEM_BYTES check guarantees the address never exceeds MEM_BYTES-1.
- Bytes already written before an ERROR stay in memory. Memory is not cleared.

## Timing
- Reset values: state LEN_LO, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, error=0, byte_count=0.
- mem_we, mem_addr and mem_wdata are registered. mem_we pulses for exactly one cycle, in the cycle after the DATA handshake. Memory captures the byte on the following edge.
- done and error are registered. They assert in the cycle after the final accepted byte (last payload byte, checksum byte, or the LEN_HI byte when N == 0 or N > MEM_BYTES). cpu_hold drops in that same cycle as done rises.
- byte_count updates in the same cycle as mem_we.
- Reset mid-load: the next cycle shows the reset values. A partial image stays in memory and the stream restarts at LEN_LO.
- A start pulse in the same cycle as rst is ignored; rst wins.
- Throughput: one byte per cycle when in_valid is held high. N payload bytes complete in N+2 handshake cycles, or N+3 with the checksum.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - An 8-bit XOR of the payload bytes (length bytes excluded) accumulates during DATA and is compared in CHECK.
  - The accumulator resets to 0x00 on rst and on start.
- LOADER_CHECKSUM_EN undefined:
  - No CHECK state and no accumulator logic.
  - DATA, or LEN_HI with N == 0, goes directly to DONE.

## Structure
- Shared package loader_pkg holds:
  - the state enumeration (S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR);
  - LEN_W = 16;
  - the stream-format field order.
- One sub-module: load_csum (XOR accumulator with clear and enable). It is instantiated only under LOADER_CHECKSUM_EN.

## Test plan
- Stream 0x04,0x00,0x20,0x08,0x00,0x64, in_valid held high → four mem_we pulses at addresses 0..3 with data 20,08,00,64. done=1 and cpu_hold=0 one cycle after the last byte. byte_count=4.
- Length 0x01,0x01 (N=257, above MEM_BYTES=256) → error=1 after LEN_HI, no mem_we pulses, cpu_hold stays 1, in_ready=0.
- Random in_valid gaps on an 8-byte image → same writes and addresses as the gap-free run; no mem_we in idle cycles.
- rst asserted after 3 of 8 payload bytes → next cycle shows all reset values. A full new 2-byte image then loads at addresses 0..1 and done=1.
- With LOADER_CHECKSUM_EN, payload 0x12,0x34 and checksum 0x26 → done=1. With checksum 0x27 → error=1. A start pulse after error, followed by a correct stream → done=1.
- N=0 (0x00,0x00) → done next cycle without checksum; with LOADER_CHECKSUM_EN, checksum byte 0x00 → done.
